// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory access unit.
// Size codes follow the load/store funct3 field.
package mem_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} mau_state_t;

  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU: size_legal = 1'b1;
      default:                                  size_legal = 1'b0;
    endcase
  endfunction

  // Byte accesses are always aligned; the unsigned flag does not affect alignment
  function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size[1:0])
      2'b01:   size_aligned = (addr_lo[0] == 1'b0);
      2'b10:   size_aligned = (addr_lo == 2'b00);
      default: size_aligned = 1'b1;
    endcase
  endfunction

  // Stores have no unsigned variants, so bu/hu collapse onto b/h
  function automatic logic [2:0] store_size(input logic [2:0] size);
    store_size = {1'b0, size[1:0]};
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of raw load data according to the access size.
module mem_load_extend
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] raw_i,
  input  logic [2:0]            size_i,
  output logic [DATA_WIDTH-1:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (size_i)
      SIZE_B:  ext_o = {{(DATA_WIDTH-8){raw_i[7]}}, raw_i[7:0]};
      SIZE_BU: ext_o = {{(DATA_WIDTH-8){1'b0}}, raw_i[7:0]};
      SIZE_H:  ext_o = {{(DATA_WIDTH-16){raw_i[15]}}, raw_i[15:0]};
      SIZE_HU: ext_o = {{(DATA_WIDTH-16){1'b0}}, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: aligned accesses pass through in one cycle,
// misaligned halfword/word accesses are split into byte transactions.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  misaligned,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_size,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 2;

  mau_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  lat_write_q, lat_write_d;
  logic [2:0]            lat_size_q, lat_size_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [DATA_WIDTH-1:0] wdata_hold_q;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic                  mis_q, mis_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic [ADDR_WIDTH-1:0] addr_c;
  logic [2:0]            size_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic                  write_c;
  logic [DATA_WIDTH-1:0] asm_c;
  logic [DATA_WIDTH-1:0] ext_raw_c;
  logic [2:0]            ext_size_c;
  logic [DATA_WIDTH-1:0] ext_data_c;
  logic [CNT_W-1:0]      last_cnt_c;

  // Split loads drop the current byte into the buffer before extension
  always_comb begin
    asm_c = buf_q;
    asm_c[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
    ext_raw_c  = (state_q == SPLIT) ? asm_c : mem_rdata;
    ext_size_c = (state_q == SPLIT) ? lat_size_q : req_size;
    last_cnt_c = (lat_size_q[1:0] == 2'b10) ? CNT_W'(3) : CNT_W'(1);
  end

  mem_load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
    .raw_i  (ext_raw_c),
    .size_i (ext_size_c),
    .ext_o  (ext_data_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    lat_write_d  = lat_write_q;
    lat_size_d   = lat_size_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    mis_d        = 1'b0;
    resp_rdata_d = '0;
    addr_c       = addr_hold_q;
    wdata_c      = wdata_hold_q;
    size_c       = SIZE_B;
    write_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!size_legal(req_size)) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (size_aligned(req_size, req_addr[1:0])) begin
            addr_c       = req_addr;
            wdata_c      = req_wdata;
            size_c       = req_write ? store_size(req_size) : req_size;
            write_c      = req_write;
            resp_valid_d = 1'b1;
            resp_rdata_d = req_write ? '0 : ext_data_c;
          end else begin
            lat_write_d = req_write;
            lat_size_d  = req_size;
            lat_addr_d  = req_addr;
            lat_wdata_d = req_wdata;
            cnt_d       = '0;
            buf_d       = '0;
            state_d     = SPLIT;
          end
        end
      end
      SPLIT: begin
        // Address arithmetic wraps naturally at the top of the byte space
        addr_c = lat_addr_q + ADDR_WIDTH'(cnt_q);
        if (lat_write_q) begin
          size_c  = SIZE_B;
          wdata_c = DATA_WIDTH'(lat_wdata_q[{cnt_q, 3'b000} +: 8]);
          write_c = 1'b1;
        end else begin
          size_c = SIZE_BU;
          buf_d  = asm_c;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last_cnt_c) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          mis_d        = 1'b1;
          resp_rdata_d = lat_write_q ? '0 : ext_data_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      buf_q        <= '0;
      lat_write_q  <= 1'b0;
      lat_size_q   <= '0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mis_q        <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      lat_write_q  <= lat_write_d;
      lat_size_q   <= lat_size_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      addr_hold_q  <= addr_c;
      wdata_hold_q <= wdata_c;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      mis_q        <= mis_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // A write must never reach memory while reset is asserted
  assign mem_write  = write_c & ~rst;
  assign mem_addr   = addr_c;
  assign mem_size   = size_c;
  assign mem_wdata  = wdata_c;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign misaligned = mis_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory plus an independent
// byte-level reference model of every load/store.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int unsigned AW        = 17;
  localparam int unsigned DW        = 32;
  localparam int unsigned MEM_BYTES = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [2:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_err, misaligned;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_size;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_write;

  logic [7:0]    dut_mem [MEM_BYTES];
  logic [7:0]    ref_mem [MEM_BYTES];
  logic          bd_fill, bd_we;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;
  logic [DW-1:0] last_rdata;

  int n_chk = 0;
  int n_err = 0;

  mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .misaligned(misaligned),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory returns the four bytes starting at the address; writes land at posedge
  always_comb begin
    mem_rdata = {dut_mem[AW'(mem_addr + 17'd3)], dut_mem[AW'(mem_addr + 17'd2)],
                 dut_mem[AW'(mem_addr + 17'd1)], dut_mem[mem_addr]};
  end

  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < MEM_BYTES; i++) dut_mem[i] = 8'(i * 37 + 11);
    end else if (bd_we) begin
      dut_mem[bd_addr] = bd_data;
    end else if (mem_write) begin
      dut_mem[mem_addr] = mem_wdata[7:0];
      if (mem_size[1:0] != 2'b00) dut_mem[AW'(mem_addr + 17'd1)] = mem_wdata[15:8];
      if (mem_size[1:0] == 2'b10) begin
        dut_mem[AW'(mem_addr + 17'd2)] = mem_wdata[23:16];
        dut_mem[AW'(mem_addr + 17'd3)] = mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    if (sz[1:0] == 2'b00) return 1;
    if (sz[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_legal(input logic [2:0] sz);
    return sz == 3'd0 || sz == 3'd1 || sz == 3'd2 || sz == 3'd4 || sz == 3'd5;
  endfunction

  // Little-endian gather with wrap, then arithmetic two's-complement extension
  function automatic logic [31:0] ref_load(input int a, input logic [2:0] sz);
    int nb = nbytes(sz);
    longint v = 0;
    longint span;
    for (int i = 0; i < nb; i++) v += longint'(ref_mem[(a + i) % MEM_BYTES]) << (8 * i);
    span = longint'(1) << (8 * nb);
    if (!sz[2] && nb < 4 && v >= span / 2) v -= span;
    return 32'(v);
  endfunction

  task automatic ref_store(input int a, input logic [2:0] sz, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[(a + i) % MEM_BYTES] = d[8 * i +: 8];
  endtask

  task automatic junk(input bit allow_valid);
    req_valid = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_size  = 3'($urandom_range(0, 7));
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    #1;
    ref_mem[a] = d;
  endtask

  // Called and returns at negedge+1; the next request may be driven immediately
  task automatic run_req(input logic w, input logic [2:0] sz, input logic [AW-1:0] a,
                         input logic [31:0] wd);
    bit legal = is_legal(sz);
    int nb = nbytes(sz);
    bit algn = (int'(a) % nb) == 0;
    logic [31:0] exp_r = (legal && !w) ? ref_load(int'(a), sz) : 32'h0;
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    #1;
    if (!legal || !algn) begin
      chk("t_nowrite", 32'(mem_write), 32'd0);
    end else begin
      chk("t_addr", 32'(mem_addr), 32'(a));
      chk("t_size", 32'(mem_size), 32'(w ? {1'b0, sz[1:0]} : sz));
      chk("t_write", 32'(mem_write), 32'(w));
      if (w) chk("t_wdata", mem_wdata, wd);
    end
    @(negedge clk);
    if (legal && !algn) begin
      for (int i = 0; i < nb; i++) begin
        junk(1'b1);
        #1;
        chk("split_ready", 32'(req_ready), 32'd0);
        chk("split_no_resp", 32'(resp_valid), 32'd0);
        chk("split_addr", 32'(mem_addr), 32'(AW'(a + AW'(i))));
        chk("split_size", 32'(mem_size), w ? 32'd0 : 32'd4);
        chk("split_write", 32'(mem_write), 32'(w));
        if (w) chk("split_wbyte", 32'(mem_wdata[7:0]), 32'(wd[8 * i +: 8]));
        @(negedge clk);
      end
    end
    junk(1'b0);
    #1;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_err", 32'(resp_err), 32'(!legal));
    chk("resp_mis", 32'(misaligned), 32'(legal && !algn));
    chk("resp_rdata", resp_rdata, exp_r);
    chk("resp_idle_wr", 32'(mem_write), 32'd0);
    if (legal) chk("hold_addr", 32'(mem_addr), 32'(AW'(a + AW'(algn ? 0 : nb - 1))));
    last_rdata = resp_rdata;
    if (legal && w) ref_store(int'(a), sz, wd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a6;
    int ndiff;
    rst = 1'b1; bd_fill = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i * 37 + 11);
    @(negedge clk);
    bd_fill = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);

    // Aligned word load
    bd_write(17'h10000, 8'hEF); bd_write(17'h10001, 8'hBE);
    bd_write(17'h10002, 8'hAD); bd_write(17'h10003, 8'hDE);
    run_req(1'b0, SIZE_W, 17'h10000, 32'h0);
    chk("t1_lw", last_rdata, 32'hDEADBEEF);

    // Misaligned word store split into four bytes
    run_req(1'b1, SIZE_W, 17'h10001, 32'h11223344);
    chk("t2_b0", 32'(dut_mem[17'h10001]), 32'h44);
    chk("t2_b1", 32'(dut_mem[17'h10002]), 32'h33);
    chk("t2_b2", 32'(dut_mem[17'h10003]), 32'h22);
    chk("t2_b3", 32'(dut_mem[17'h10004]), 32'h11);

    // Misaligned halfword loads, signed and unsigned; second follows back-to-back
    bd_write(17'h10003, 8'h80); bd_write(17'h10004, 8'hFF);
    run_req(1'b0, SIZE_H, 17'h10003, 32'h0);
    chk("t3_lh", last_rdata, 32'hFFFFFF80);
    run_req(1'b0, SIZE_HU, 17'h10003, 32'h0);
    chk("t3_lhu", last_rdata, 32'h0000FF80);

    // Back-to-back byte loads, one per cycle
    for (int k = 0; k <= 8; k++) begin
      logic [31:0] exp_b;
      exp_b = ref_load(32'h10000 + k - 1, SIZE_B);
      if (k < 8) begin
        req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_B;
        req_addr = AW'(32'h10000 + k); req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (k > 0) begin
        chk("t4_valid", 32'(resp_valid), 32'd1);
        chk("t4_mis", 32'(misaligned), 32'd0);
        chk("t4_rdata", resp_rdata, exp_b);
      end
      if (k < 8) begin
        chk("t4_ready", 32'(req_ready), 32'd1);
        chk("t4_addr", 32'(mem_addr), 32'h10000 + k);
      end
      @(negedge clk);
      #1;
    end

    // Split store wrapping past the top of the address space
    run_req(1'b1, SIZE_W, 17'h1FFFF, 32'hCAFEF00D);
    chk("t5_wrap0", 32'(dut_mem[17'h1FFFF]), 32'h0D);
    chk("t5_wrap3", 32'(dut_mem[17'h00002]), 32'hCA);

    // Reset two cycles into a split store
    a6 = 17'h10021;
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_W; req_addr = a6; req_wdata = 32'hA1B2C3D4;
    #1;
    chk("t6_t_nowrite", 32'(mem_write), 32'd0);
    @(negedge clk);
    junk(1'b0);
    #1;
    chk("t6_b0_write", 32'(mem_write), 32'd1);
    chk("t6_b0_addr", 32'(mem_addr), 32'(a6));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("t6_no_resp2", 32'(resp_valid), 32'd0);
    ref_mem[a6] = 8'hD4;
    chk("t6_b0_mem", 32'(dut_mem[a6]), 32'hD4);
    chk("t6_b1_mem", 32'(dut_mem[AW'(a6 + 17'd1)]), 32'(ref_mem[AW'(a6 + 17'd1)]));

    // Illegal size
    run_req(1'b1, 3'b011, 17'h10010, 32'h55667788);
    chk("t7_err_rdata", last_rdata, 32'h0);

    // Randomized mix of sizes, directions and addresses with idle gaps
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] ra;
      int gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        junk(1'b0);
        #1;
        chk("gap_no_resp", 32'(resp_valid), 32'd0);
        chk("gap_no_write", 32'(mem_write), 32'd0);
      end
      ra = ($urandom_range(0, 1) == 1) ? AW'(32'h1FFF0 + $urandom_range(0, 15))
                                       : AW'(32'h10000 + $urandom_range(0, 31));
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
    end

    ndiff = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (dut_mem[i] !== ref_mem[i]) ndiff++;
    chk("mem_final_diffs", 32'(ndiff), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
